// File: rtl/dmem_responder_pkg.sv
// Shared pipeline types for the data-memory responder.
// Holds the pipeline handshake types (Signal, Register, RegAddr, M_input,
// M_output), the responder FSM state enum, the response bundle struct and
// the default geometry/latency values used by dmem_responder and dmem_array.
package dmem_responder_pkg;

    // Word-index width of the data memory: 2^DefaultMemAddrWidth words
    localparam int DefaultMemAddrWidth = 4;

    // Cycles from load acceptance to response; legal range is 1..15
    localparam int DefaultReadLatency = 2;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    typedef logic [31:0] Register;
    typedef logic [4:0]  RegAddr;

    // Memory-stage payload: byte address, store value, load destination
    typedef struct packed {
        Register addr;
        Register val;
        RegAddr  dst;
    } M_data;

    // Memory-stage request (71 bits)
    typedef struct packed {
        Signal read;
        Signal write;
        M_data data;
    } M_input;

    // Load data returned to writeback (32 bits)
    typedef Register M_output;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } MemState;

    // Completed-load bundle as presented on the response outputs
    typedef struct packed {
        Signal   valid;
        Register val;
        RegAddr  dst;
    } M_rsp;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data-memory storage for dmem_responder.
// 2^AddrWidth x 32-bit register array with one synchronous write port, one
// asynchronous read port and a synchronous clear of every word on reset.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high clear of all words
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational from raddr_i)
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int AddrWidth = DefaultMemAddrWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  Register              wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output Register              rdata_o
);

    localparam int Depth = 1 << AddrWidth;

    Register mem_q [Depth];

    // Storage: reset clears every word so a reset mid-load also wipes
    // previously stored data; otherwise a single word is written per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read lets a load snapshot the word at its acceptance edge,
    // which already reflects any store committed on an earlier edge.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory/writeback boundary.
// Stores commit in one cycle; loads are snapshotted on acceptance and
// returned ReadLatency cycles later as a one-cycle response pulse, with
// stall held high while the load is outstanding.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (aborts any outstanding load)
//   req        memory-stage request (read, write, addr/val/dst)
//   rsp        load data, zero unless rsp_valid
//   rsp_valid  one-cycle load completion pulse
//   rsp_dst    destination register of the completed load, zero unless valid
//   stall      ENABLE while a load is outstanding
//   misalign   pulse the cycle after an accepted access with addr[1:0] != 0
//   conflict   pulse the cycle after a request with both read and write set
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MemAddrWidth = DefaultMemAddrWidth,
    parameter int ReadLatency  = DefaultReadLatency
) (
    input  logic    clk,
    input  logic    reset,
    input  M_input  req,
    output M_output rsp,
    output logic    rsp_valid,
    output RegAddr  rsp_dst,
    output Signal   stall,
    output logic    misalign,
    output logic    conflict
);

    MemState                 state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    Register                 snapVal_q, snapVal_d;
    RegAddr                  snapDst_q, snapDst_d;
    logic                    misalign_q, misalign_d;
    logic                    conflict_q, conflict_d;

    logic [MemAddrWidth-1:0] wordIdx;
    Register                 memRdata;
    logic                    memWe;
    logic                    anyAccess;
    logic                    isLoad;
    M_rsp                    rspBundle;
    logic                    unusedAddrBits;

    // Upper address bits wrap away; only the word index selects storage.
    assign wordIdx        = req.data.addr[MemAddrWidth+1:2];
    assign unusedAddrBits = ^req.data.addr[31:MemAddrWidth+2];

    assign anyAccess = (req.read == ENABLE) || (req.write == ENABLE);
    assign isLoad    = (req.read == ENABLE) && (req.write == DISABLE);

    // A write wins over a simultaneous read, and requests are only honoured
    // in MEM_IDLE so the held request during WAIT/RESP never re-writes.
    assign memWe = (state_q == MEM_IDLE) && (req.write == ENABLE);

    dmem_array #(
        .AddrWidth(MemAddrWidth)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (memWe),
        .waddr_i (wordIdx),
        .wdata_i (req.data.val),
        .raddr_i (wordIdx),
        .rdata_o (memRdata)
    );

    // Next-state logic: accept requests in MEM_IDLE, count down the read
    // latency in MEM_WAIT and present the snapshot for one cycle in MEM_RESP.
    // Flags are only produced on acceptance, so ignored requests never flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snapVal_d  = snapVal_q;
        snapDst_d  = snapDst_q;
        misalign_d = 1'b0;
        conflict_d = 1'b0;
        stall      = DISABLE;

        case (state_q)
            MEM_IDLE: begin
                if (anyAccess) begin
                    misalign_d = (req.data.addr[1:0] != 2'b00);
                    conflict_d = (req.read == ENABLE) && (req.write == ENABLE);
                end
                if (isLoad) begin
                    snapVal_d = memRdata;
                    snapDst_d = req.data.dst;
                    cnt_d     = 4'(ReadLatency - 1);
                    stall     = ENABLE;
                    state_d   = (ReadLatency == 1) ? MEM_RESP : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stall = ENABLE;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = MEM_RESP;
                end
            end
            MEM_RESP: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Response bundle is gated to zero outside MEM_RESP.
    always_comb begin
        rspBundle.valid = (state_q == MEM_RESP) ? ENABLE : DISABLE;
        rspBundle.val   = (state_q == MEM_RESP) ? snapVal_q : '0;
        rspBundle.dst   = (state_q == MEM_RESP) ? snapDst_q : '0;
    end

    assign rsp       = rspBundle.val;
    assign rsp_dst   = rspBundle.dst;
    assign rsp_valid = (rspBundle.valid == ENABLE);
    assign misalign  = misalign_q;
    assign conflict  = conflict_q;

    // State, counter, snapshot and flag registers; reset drops any
    // outstanding load so no response is ever produced for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            snapVal_q  <= '0;
            snapDst_q  <= '0;
            misalign_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snapVal_q  <= snapVal_d;
            snapDst_q  <= snapDst_d;
            misalign_q <= misalign_d;
            conflict_q <= conflict_d;
        end
    end

endmodule
